// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised backing store behind the data cache.
// Accepts one read or 4-byte write at a time and completes it LATENCY cycles
// after acceptance with a single-cycle mem_ready pulse (mem_error qualifies it).
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_en,
    input  logic [7:0]  mem_data_in  [0:3],
    output logic [7:0]  mem_data_out [0:3],
    output logic        mem_ready,
    output logic        mem_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   dout_q, dout_d;

    // Storage is deliberately not reset; contents survive rst_b.
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   req_widx;
    logic          req_oor;
    logic [31:0]   rd_word;
    logic [31:0]   resp_word;
    logic [31:0]   out_word;
    logic [1:0]    unused_addr_lsb;

    // Byte offset within the word plays no role in a word-wide access.
    assign unused_addr_lsb = mem_addr[1:0];

    // Range check on the full word index, before any truncation, so that
    // out-of-range requests cannot alias onto a real word.
    assign req_widx = {2'b00, mem_addr[31:2]};
    assign req_oor  = (req_widx >= DEPTH_WORDS);

    // Lane k lives in bits [8k+7:8k]; lane 0 is the lowest byte address.
    assign rd_word   = mem_q[idx_q];
    assign resp_word = oor_q ? 32'h0 : (we_q ? wdata_q : rd_word);

    assign mem_ready = (state_q == RESP);
    assign mem_error = mem_ready && oor_q;
    // During RESP show the live response; afterwards hold the last one.
    assign out_word  = mem_ready ? resp_word : dout_q;

    // Unpack the response word onto the byte lanes.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mem_data_out[k] = out_word[8*k +: 8];
        end
    end

    // Next-state logic: capture in IDLE, count down in BUSY, respond in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    idx_d   = mem_addr[AW+1:2];
                    we_d    = mem_write_en;
                    oor_d   = req_oor;
                    wdata_d = {mem_data_in[3], mem_data_in[2],
                               mem_data_in[1], mem_data_in[0]};
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                dout_d  = resp_word;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and captured-request registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
        end
    end

    // Commit an in-range write on the edge that ends RESP, unless reset lands
    // on that same edge.
    always_ff @(posedge clk) begin
        if (rst_b && state_q == RESP && we_q && !oor_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (LATENCY 4 and 1),
// a word-array reference model, and per-instance monitors that pop expected
// responses whenever mem_ready is seen.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 4;
    localparam int LAT1  = 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req0, we0, rdy0, err0;
    logic        req1, we1, rdy1, err1;
    logic [31:0] addr0, addr1;
    logic [7:0]  din0 [0:3];
    logic [7:0]  din1 [0:3];
    logic [7:0]  dout0 [0:3];
    logic [7:0]  dout1 [0:3];
    logic [31:0] dout0w, dout1w;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          nf [2];
    logic [31:0] mdl [2][DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign dout0w = {dout0[3], dout0[2], dout0[1], dout0[0]};
    assign dout1w = {dout1[3], dout1[2], dout1[1], dout1[0]};

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_l4 (
        .clk(clk), .rst_b(rst_b), .mem_req(req0), .mem_addr(addr0),
        .mem_write_en(we0), .mem_data_in(din0), .mem_data_out(dout0),
        .mem_ready(rdy0), .mem_error(err0)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_l1 (
        .clk(clk), .rst_b(rst_b), .mem_req(req1), .mem_addr(addr1),
        .mem_write_en(we1), .mem_data_in(din1), .mem_data_out(dout1),
        .mem_ready(rdy1), .mem_error(err1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int d, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            req0 = req; we0 = we; addr0 = a;
            for (int k = 0; k < 4; k++) din0[k] = wd[8*k +: 8];
        end else begin
            req1 = req; we1 = we; addr1 = a;
            for (int k = 0; k < 4; k++) din1[k] = wd[8*k +: 8];
        end
    endtask

    // Reference behaviour of one accepted request, applied in issue order.
    function automatic exp_t model(input int d, input bit we, input logic [31:0] a,
                                   input logic [31:0] wd, input int ready_cyc);
        exp_t        x;
        int unsigned widx;
        widx    = a / 4;
        x.cyc   = ready_cyc;
        if (widx >= DEPTH) begin
            x.err  = 1'b1;
            x.data = 32'h0;
        end else if (we) begin
            x.err        = 1'b0;
            x.data       = wd;
            mdl[d][widx] = wd;
        end else begin
            x.err  = 1'b0;
            x.data = mdl[d][widx];
        end
        return x;
    endfunction

    // Drive one cycle's inputs; decide acceptance from the one-at-a-time rule.
    task automatic cyc_drive(input int d, input bit req, input bit we,
                             input logic [31:0] a, input logic [31:0] wd,
                             input bit record, output bit acc);
        int   e;
        int   lat;
        exp_t x;
        @(negedge clk);
        drive(d, req, we, a, wd);
        lat = (d == 0) ? LAT0 : LAT1;
        e   = cyc + 1;
        acc = req && rst_b && (e >= nf[d]);
        if (acc) begin
            nf[d] = e + lat + 1;
            if (record) begin
                x = model(d, we, a, wd, e + lat - 1);
                if (d == 0) q0.push_back(x);
                else        q1.push_back(x);
            end
        end
    endtask

    task automatic req_once(input int d, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, output int acc_edge);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 64) begin
            cyc_drive(d, 1'b1, we, a, wd, 1'b1, acc);
            n++;
        end
        chk("accept_bound", {63'h0, acc}, 64'h1);
        acc_edge = cyc + 1;
    endtask

    task automatic idle(input int d, input int n);
        bit acc;
        repeat (n) cyc_drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    endtask

    // Monitor for the LATENCY=4 instance.
    always @(negedge clk) begin
        exp_t x;
        if (rdy0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("l4_spurious_ready", 64'h1, 64'h0);
            end else begin
                x = q0.pop_front();
                chk("l4_ready_cycle", 64'(cyc), 64'(x.cyc));
                chk("l4_error", {63'h0, err0}, {63'h0, x.err});
                chk("l4_data", {32'h0, dout0w}, {32'h0, x.data});
            end
        end else if (cyc > 0) begin
            chk("l4_error_idle", {63'h0, err0}, 64'h0);
        end
    end

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        exp_t x;
        if (rdy1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("l1_spurious_ready", 64'h1, 64'h0);
            end else begin
                x = q1.pop_front();
                chk("l1_ready_cycle", 64'(cyc), 64'(x.cyc));
                chk("l1_error", {63'h0, err1}, {63'h0, x.err});
                chk("l1_data", {32'h0, dout1w}, {32'h0, x.data});
            end
        end else if (cyc > 0) begin
            chk("l1_error_idle", {63'h0, err1}, 64'h0);
        end
    end

    initial begin
        bit          acc;
        int          e;
        logic [31:0] v;
        int          n;

        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mdl[0][i] = v;
            u_l4.mem_q[i] = v;
            v = $urandom;
            mdl[1][i] = v;
            u_l1.mem_q[i] = v;
        end
        nf[0] = 0;
        nf[1] = 0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        // Request raised during reset must be dropped.
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready_l4", {63'h0, rdy0}, 64'h0);
        chk("rst_error_l4", {63'h0, err0}, 64'h0);
        chk("rst_data_l4", {32'h0, dout0w}, 64'h0);
        chk("rst_ready_l1", {63'h0, rdy1}, 64'h0);
        chk("rst_error_l1", {63'h0, err1}, 64'h0);
        chk("rst_data_l1", {32'h0, dout1w}, 64'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_b = 1'b1;

        // Write then read back through a different byte offset of the word.
        req_once(0, 1'b1, 32'h0000_0010, 32'h4433_2211, e);
        req_once(0, 1'b0, 32'h0000_0013, 32'h0, e);
        idle(0, 2);

        // mem_req held high with a fresh address every cycle.
        for (int i = 0; i < 30; i++) begin
            cyc_drive(0, 1'b1, 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 32'h0FFF)), $urandom, 1'b1, acc);
        end
        idle(0, 6);

        // Out-of-range write must not alias onto word 0.
        req_once(0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, e);
        req_once(0, 1'b0, 32'h0000_0000, 32'h0, e);
        idle(0, 6);

        // Reset two cycles after accepting a write aborts it.
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 16) begin
            cyc_drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, acc);
            n++;
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        chk("abort_ready", {63'h0, rdy0}, 64'h0);
        chk("abort_error", {63'h0, err0}, 64'h0);
        chk("abort_data", {32'h0, dout0w}, 64'h0);
        rst_b = 1'b1;
        nf[0] = 0;
        nf[1] = 0;
        req_once(0, 1'b0, 32'h0000_0020, 32'h0, e);
        idle(0, 6);

        // Preloaded word read, then output holds through idle cycles.
        req_once(0, 1'b0, 32'h0000_03FC, 32'h0, e);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        while (cyc < e + LAT0) @(negedge clk);
        repeat (3) begin
            chk("hold_ready", {63'h0, rdy0}, 64'h0);
            chk("hold_data", {32'h0, dout0w}, {32'h0, mdl[0][255]});
            @(negedge clk);
        end

        // Random mix with idle gaps, including out-of-range addresses.
        for (int i = 0; i < 120; i++) begin
            idle(0, $urandom_range(0, 3));
            req_once(0, 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 32'h17FF)), $urandom, e);
        end
        idle(0, 6);

        // LATENCY=1: back-to-back reads with mem_req held high.
        req_once(1, 1'b0, 32'h0000_0000, 32'h0, e);
        req_once(1, 1'b0, 32'h0000_0004, 32'h0, e);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1, 1);
            req_once(1, 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 32'h17FF)), $urandom, e);
        end
        idle(1, 1);

        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(q0.size() + q1.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that answers the core's MEM-stage memory port. It accepts one request at a time, either a read or a 4-byte write, and completes it after a fixed, parameterised latency. This models the slow backing store behind the data cache. It sits at the far end of `mem_addr` / `mem_data_in` / `mem_write_en` / `mem_data_out` and adds a req/ready handshake so the cache can stall on misses.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words stored; must be a power of two.
- `LATENCY`, 4: cycles from request acceptance to `mem_ready`; legal range 1..15.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_b`, input, 1: reset, synchronous and active-low.
- `mem_req`, input, 1: request strobe; sampled only in IDLE.
- `mem_addr`, input, 32: byte address. The word index is `mem_addr[31:2]`; `mem_addr[1:0]` is ignored.
- `mem_write_en`, input, 1: 1 = write request, 0 = read request. Sampled with `mem_req`.
- `mem_data_in`, input, 4x8 (`[7:0] [0:3]`): write data. Lane k goes to byte address word_base+k.
- `mem_data_out`, output, 4x8 (`[7:0] [0:3]`): read data. Lane k comes from byte address word_base+k.
- `mem_ready`, output, 1: one-cycle completion pulse for the request in flight.
- `mem_error`, output, 1: qualifies `mem_ready`; 1 means the word index was out of range.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If `mem_req`=1, capture the address, write enable, the four data lanes, and a range flag (word index >= `DEPTH_WORDS`).
  - Load the down-counter with `LATENCY`-1.
  - Go to RESP if `LATENCY`=1, otherwise go to BUSY.
- BUSY:
  - Decrement the counter every cycle.
  - When the counter equals 1, move to RESP on the next edge.
  - Inputs are ignored in BUSY; `mem_req` is neither queued nor acknowledged.
- RESP, held for exactly one cycle, then return to IDLE:
  - Assert `mem_ready`=1.
  - In-range write: commit all four lanes of the captured word on the edge that ends RESP. Drive `mem_data_out` with the written data (write-through echo).
  - In-range read: drive `mem_data_out` with the stored word. A write committed earlier is visible.
  - Out of range: no storage change, `mem_data_out`=0, `mem_error`=1.
- Captured request fields are frozen from acceptance to RESP, so input changes after acceptance have no effect.
- Storage width is 32 bits. The word index is truncated to log2(`DEPTH_WORDS`) bits only after the range check passes, so an out-of-range index never aliases.
- Storage contents are not cleared by reset. The bench preloads storage by hierarchical access.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `mem_ready`=0, `mem_error`=0, `mem_data_out`=all lanes 0.
- Latency: a request accepted at edge t gives `mem_ready`=1 during the cycle after edge t+`LATENCY`-1, i.e. `LATENCY` cycles after acceptance.
- Throughput: the minimum spacing between accepted requests is `LATENCY`+1 cycles. A `mem_req` held high through RESP is accepted in the following IDLE cycle.
- `mem_data_out` holds its last driven value after RESP until the next RESP or reset. It is only meaningful while `mem_ready`=1.
- `mem_error` is 0 whenever `mem_ready` is 0.
- Reset mid-operation (`rst_b`=0 in BUSY or RESP):
  - The next edge returns to IDLE with reset values.
  - A pending write is not committed if reset arrives before the RESP edge completes.
  - No `mem_ready` pulse is produced for the aborted request.
- `mem_req` together with `rst_b`=0: reset wins and the request is dropped.

## Test plan
- Write then read, `LATENCY`=4:
  - Write addr 0x0000_0010, lanes {0x11,0x22,0x33,0x44}; `mem_ready` arrives 4 cycles after acceptance with `mem_error`=0.
  - Read addr 0x0000_0013; returns {0x11,0x22,0x33,0x44} 4 cycles later.
- Busy rejection: hold `mem_req`=1 continuously with a new address each cycle.
  - Exactly one `mem_ready` per 5 cycles.
  - Each response matches the address present on that request's acceptance cycle.
- Out of range, `DEPTH_WORDS`=1024:
  - Write addr 0x0000_1000 with `mem_ready`=1 and `mem_error`=1; data_out = 0.
  - A subsequent read of addr 0x0 returns its preloaded value unchanged (no aliasing).
- Reset abort: issue a write of 0xDEADBEEF to addr 0x20, then pull `rst_b` low 2 cycles after acceptance.
  - No `mem_ready` appears; all outputs are 0 after the edge.
  - A read of 0x20 returns the old contents.
- `LATENCY`=1: back-to-back reads of addr 0x0 and 0x4 with `mem_req` held high give `mem_ready` pulses 2 cycles apart, each carrying the correct data.
- Read of an unwritten, preloaded word 0x3FC returns its preload. `mem_data_out` holds that value through the following idle cycles.
